// File: rtl/bomb_game_pkg.sv
// Shared definitions for the bomb game controller.
//   state_e   : FSM state encoding; the numeric values are visible on the
//               controller's state output.
//   BCD_MAX   : largest digit the keypad may legally enter.
//   EXPIRED   : countdown value {tens,units} that signals underflow.
//   code_mask : selects the low 4*len bits that hold a len-digit code.
package bomb_game_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        DEFUSED  = 2'd2,
        EXPLODED = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [7:0] EXPIRED = 8'hFF;

    function automatic logic [15:0] code_mask(input int unsigned len);
        code_mask = 16'hFFFF >> (16 - 4 * len);
    endfunction

endpackage

// File: rtl/code_entry.sv
// Digit buffer for the defuse code.
// Collects accepted digits; when the CODE_LEN-th digit arrives it compares
// the full code with SECRET in that same cycle and pulses done (and match
// if equal) for one cycle, then starts a fresh attempt.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear of buffer and count
//   accept   : digit is valid and allowed this cycle
//   digit    : BCD digit being accepted
//   done     : pulse, the final digit of an attempt was accepted
//   match    : pulse, qualifies done when the attempt equals SECRET
module code_entry
    import bomb_game_pkg::*;
#(
    parameter int unsigned CODE_LEN = 4,
    parameter logic [15:0] SECRET   = 16'h1234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       accept,
    input  logic [3:0] digit,
    output logic       done,
    output logic       match
);

    localparam logic [15:0] MASK = code_mask(CODE_LEN);
    localparam logic [2:0]  LAST = 3'(CODE_LEN - 1);

    // Only CODE_LEN-1 digits ever need to be stored; the last one is
    // compared straight from the input.
    logic [11:0] buf_q, buf_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] code_now;

    always_comb begin
        code_now = {buf_q, digit};
        done     = accept && (cnt_q == LAST);
        match    = done && ((code_now & MASK) == (SECRET & MASK));
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        if (clr || done) begin
            buf_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            buf_d = code_now[11:0];
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bomb_game_ctrl.sv
// Bomb game controller: arm, enter a BCD defuse code against a countdown,
// with limited tries and a key lockout after each wrong attempt.
//   clk, rst        : clock, async active-high reset
//   btn_arm         : pulse; arms from IDLE, returns to IDLE after the game
//   key_valid/val   : keypad strobe and digit
//   cnt_s1, cnt_s2  : countdown units/tens; 8'hFF means time ran out
//   start           : countdown run enable (high exactly while ARMED)
//   success, boom   : game outcome flags, held until re-armed
//   state           : current FSM state
//   tries_left      : wrong attempts still allowed
//   lockout         : keys are being ignored after a wrong attempt
module bomb_game_ctrl
    import bomb_game_pkg::*;
#(
    parameter int unsigned CODE_LEN    = 4,
    parameter logic [15:0] SECRET      = 16'h1234,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned PENALTY_CYC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_arm,
    input  logic       key_valid,
    input  logic [3:0] key_val,
    input  logic [3:0] cnt_s1,
    input  logic [3:0] cnt_s2,
    output logic       start,
    output logic       success,
    output logic       boom,
    output logic [1:0] state,
    output logic [1:0] tries_left,
    output logic       lockout
);

    state_e      state_q, state_d;
    logic [1:0]  tries_q, tries_d;
    logic [7:0]  pen_q, pen_d;
    logic        start_q, success_q, boom_q, lockout_q;
    logic        accept, expired, clr, done, match;

    assign accept  = (state_q == ARMED) && key_valid && (key_val <= BCD_MAX) && !lockout_q;
    assign expired = (state_q == ARMED) && ({cnt_s2, cnt_s1} == EXPIRED);
    assign clr     = (state_q == IDLE) && btn_arm;

    code_entry #(
        .CODE_LEN (CODE_LEN),
        .SECRET   (SECRET)
    ) u_code (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .accept (accept),
        .digit  (key_val),
        .done   (done),
        .match  (match)
    );

    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        pen_d   = (pen_q != 8'd0) ? pen_q - 8'd1 : 8'd0;
        case (state_q)
            IDLE: begin
                if (btn_arm) begin
                    state_d = ARMED;
                    tries_d = 2'(MAX_TRIES);
                end
            end
            ARMED: begin
                // Running out of time wins over a correct final digit.
                if (expired) begin
                    state_d = EXPLODED;
                end else if (match) begin
                    state_d = DEFUSED;
                end else if (done) begin
                    tries_d = tries_q - 2'd1;
                    if (tries_q == 2'd1) state_d = EXPLODED;
                    else                 pen_d   = 8'(PENALTY_CYC);
                end
            end
            DEFUSED, EXPLODED: begin
                if (btn_arm) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Penalty only has meaning inside a running game.
        if (state_d != ARMED) pen_d = 8'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tries_q   <= 2'd0;
            pen_q     <= 8'd0;
            start_q   <= 1'b0;
            success_q <= 1'b0;
            boom_q    <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tries_q   <= tries_d;
            pen_q     <= pen_d;
            start_q   <= (state_d == ARMED);
            success_q <= (state_d == DEFUSED);
            boom_q    <= (state_d == EXPLODED);
            lockout_q <= (pen_d != 8'd0);
        end
    end

    assign state      = state_q;
    assign tries_left = tries_q;
    assign start      = start_q;
    assign success    = success_q;
    assign boom       = boom_q;
    assign lockout    = lockout_q;

endmodule

// File: tb/tb_bomb_game_ctrl.sv
module tb_bomb_game_ctrl;

    localparam int unsigned CODE_LEN  = 4;
    localparam logic [15:0] SECRET    = 16'h1234;
    localparam int unsigned MAX_TRIES = 3;
    localparam int unsigned PEN       = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arm = 1'b0;
    logic       kv  = 1'b0;
    logic [3:0] kval = 4'd0;
    logic [3:0] cs1 = 4'h9;
    logic [3:0] cs2 = 4'h5;
    logic       d_start, d_success, d_boom, d_lockout;
    logic [1:0] d_state, d_tries;

    int checks = 0;
    int errors = 0;

    // Reference model: game rules in plain terms.
    int m_state = 0;
    int m_tries = 0;
    int m_lock  = 0;
    int m_dig[$];

    bomb_game_ctrl #(
        .CODE_LEN    (CODE_LEN),
        .SECRET      (SECRET),
        .MAX_TRIES   (MAX_TRIES),
        .PENALTY_CYC (PEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_arm    (arm),
        .key_valid  (kv),
        .key_val    (kval),
        .cnt_s1     (cs1),
        .cnt_s2     (cs2),
        .start      (d_start),
        .success    (d_success),
        .boom       (d_boom),
        .state      (d_state),
        .tries_left (d_tries),
        .lockout    (d_lockout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_tries = 0;
        m_lock  = 0;
        m_dig.delete();
    endtask

    task automatic model_edge();
        bit took;
        int val;
        int mask;
        mask = (1 << (4 * CODE_LEN)) - 1;
        case (m_state)
            0: if (arm) begin
                m_state = 1;
                m_tries = MAX_TRIES;
                m_lock  = 0;
                m_dig.delete();
            end
            1: begin
                took = kv && (kval <= 9) && (m_lock == 0);
                if (m_lock > 0) m_lock--;
                if ({cs2, cs1} == 8'hFF) begin
                    m_state = 3;
                    m_lock  = 0;
                end else if (took) begin
                    m_dig.push_back(int'(kval));
                    if (m_dig.size() == CODE_LEN) begin
                        val = 0;
                        foreach (m_dig[i]) val = val * 16 + m_dig[i];
                        m_dig.delete();
                        if (val == (int'(SECRET) & mask)) begin
                            m_state = 2;
                        end else begin
                            m_tries--;
                            if (m_tries == 0) m_state = 3;
                            else              m_lock  = PEN;
                        end
                    end
                end
            end
            default: if (arm) m_state = 0;
        endcase
    endtask

    task automatic compare();
        chk("state",   32'(d_state),   32'(m_state));
        chk("start",   32'(d_start),   32'(m_state == 1));
        chk("success", 32'(d_success), 32'(m_state == 2));
        chk("boom",    32'(d_boom),    32'(m_state == 3));
        chk("tries",   32'(d_tries),   32'(m_tries));
        chk("lockout", 32'(d_lockout), 32'(m_lock > 0));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic press(input logic [3:0] d);
        kv   = 1'b1;
        kval = d;
        step();
        kv   = 1'b0;
    endtask

    task automatic wrong_code();
        repeat (CODE_LEN) press(4'd9);
        repeat (PEN) step();
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic async_reset();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        compare();
        chk("arst_state", 32'(d_state), 32'd0);
        chk("arst_start", 32'(d_start), 32'd0);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] nd;
        #12;
        model_reset();
        compare();
        chk("rst_tries", 32'(d_tries), 32'd0);
        rst = 1'b0;

        // Correct code defuses; start drops with the 4th key.
        arm_pulse();
        chk("arm_start", 32'(d_start), 32'd1);
        chk("arm_tries", 32'(d_tries), 32'd3);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        chk("def_state", 32'(d_state), 32'd2);
        chk("def_succ",  32'(d_success), 32'd1);
        chk("def_start", 32'(d_start), 32'd0);
        arm_pulse();
        chk("back_idle", 32'(d_state), 32'd0);

        // Wrong code, lockout window, ignored key, then correct code.
        arm_pulse();
        press(4'd1); press(4'd2); press(4'd3); press(4'd5);
        chk("wr_tries", 32'(d_tries), 32'd2);
        chk("wr_lock",  32'(d_lockout), 32'd1);
        press(4'd1);
        repeat (6) step();
        chk("lock_last", 32'(d_lockout), 32'd1);
        step();
        chk("lock_end", 32'(d_lockout), 32'd0);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        chk("wr_def", 32'(d_state), 32'd2);
        arm_pulse();

        // Three wrong codes detonate.
        arm_pulse();
        wrong_code();
        wrong_code();
        repeat (CODE_LEN) press(4'd9);
        chk("ex_boom",  32'(d_boom), 32'd1);
        chk("ex_state", 32'(d_state), 32'd3);
        chk("ex_tries", 32'(d_tries), 32'd0);
        arm_pulse();

        // Countdown underflow.
        arm_pulse();
        {cs2, cs1} = 8'hFF;
        step();
        {cs2, cs1} = 8'h59;
        chk("exp_state", 32'(d_state), 32'd3);
        arm_pulse();

        // Underflow together with the correct final digit.
        arm_pulse();
        press(4'd1); press(4'd2); press(4'd3);
        {cs2, cs1} = 8'hFF;
        press(4'd4);
        {cs2, cs1} = 8'h59;
        chk("exp_prio", 32'(d_state), 32'd3);
        arm_pulse();

        // Non-BCD key is discarded mid-entry.
        arm_pulse();
        press(4'd1); press(4'hA); press(4'd2); press(4'd3); press(4'd4);
        chk("nbcd_def", 32'(d_state), 32'd2);
        arm_pulse();

        // Reset mid-game.
        arm_pulse();
        press(4'd1);
        async_reset();
        step();

        // Randomized play, biased toward the correct next digit.
        for (int n = 0; n < 3000; n++) begin
            arm = ($urandom_range(7) == 0);
            kv  = $urandom_range(1);
            nd  = 4'((SECRET >> (4 * (CODE_LEN - 1 - m_dig.size()))) & 16'hF);
            if ($urandom_range(3) != 0) kval = nd;
            else                        kval = 4'($urandom_range(15));
            if ($urandom_range(59) == 0) {cs2, cs1} = 8'hFF;
            else                         {cs2, cs1} = 8'($urandom_range(254));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bomb_game_ctrl.md
BOMB_GAME_CTRL -- requirements
Module: bomb_game_ctrl

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4, meaning number of BCD digits in the defuse code (1..4).
REQ-002 SHALL have parameter SECRET, default 16'h1234, meaning the defuse code, packed as digits with the first-entered digit in the MS nibble of the used field.
REQ-003 SHALL have parameter MAX_TRIES, default 3, meaning wrong attempts allowed before detonation (1..3).
REQ-004 SHALL have parameter PENALTY_CYC, default 8, meaning clk cycles for which keys are ignored after a wrong attempt (1..255).
REQ-005 SHALL have port clk, input, 1, meaning the single system clock.
REQ-006 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-007 SHALL have port btn_arm, input, 1, meaning one-cycle pulse to arm or restart, already synchronised.
REQ-008 SHALL have port key_valid, input, 1, meaning one-cycle strobe qualifying key_val.
REQ-009 SHALL have port key_val, input, 4, meaning entered digit.
REQ-010 SHALL have port cnt_s1, input, 4, meaning the countdown units digit.
REQ-011 SHALL have port cnt_s2, input, 4, meaning the countdown tens digit.
REQ-012 SHALL have port start, output, 1, meaning run enable to the countdown.
REQ-013 SHALL have port success, output, 1, meaning the bomb is defused.
REQ-014 SHALL have port boom, output, 1, meaning the bomb has exploded.
REQ-015 SHALL have port state, output, 2, meaning the current FSM state.
REQ-016 SHALL have port tries_left, output, 2, meaning remaining attempts.
REQ-017 SHALL have port lockout, output, 1, meaning the penalty window is active.

Function
REQ-018 SHALL implement FSM states IDLE=0, ARMED=1, DEFUSED=2, EXPLODED=3; all outputs registered.
REQ-019 SHALL transition IDLE->ARMED on btn_arm, loading tries_left=MAX_TRIES and clearing the digit buffer, digit count and lockout.
REQ-020 SHALL drive start=1 exactly while state==ARMED, with start rising on the clk edge that enters ARMED.
REQ-021 SHALL, in ARMED with lockout=0, accept a digit on key_valid=1 only when key_val<=9; values 10..15 are discarded without counting.
REQ-022 SHALL compare the buffer against SECRET in the same cycle the CODE_LEN-th digit is accepted; on match, ARMED->DEFUSED at the next edge.
REQ-023 SHALL, on mismatch, decrement tries_left, clear the buffer, and assert lockout for PENALTY_CYC cycles; if tries_left was 1, go ARMED->EXPLODED instead.
REQ-024 SHALL treat {cnt_s2,cnt_s1}==8'hFF (countdown underflow) while ARMED as expiry: ARMED->EXPLODED.
REQ-025 SHALL give expiry priority when expiry coincides with a correct final digit: the result is EXPLODED.
REQ-026 SHALL ignore btn_arm while ARMED and ignore key_valid in IDLE, DEFUSED and EXPLODED.
REQ-027 SHALL drive success=1 exactly in DEFUSED and boom=1 exactly in EXPLODED, holding each until btn_arm returns the FSM to IDLE.
REQ-028 SHALL start the lockout counter at PENALTY_CYC and decrement it to 0; lockout=1 while it is nonzero, and key_valid during lockout is dropped.

Reset
REQ-029 SHALL, while rst=1, asynchronously force state=IDLE, start=0, success=0, boom=0, tries_left=0, lockout=0, and clear the digit buffer and counters.
REQ-030 SHALL, on rst asserted mid-game, abandon the game; the countdown sees start=0 and reloads.

Structure
REQ-031 SHALL place the state encoding, BCD_MAX=9 and EXPIRED=8'hFF constants in shared package bomb_game_pkg.
REQ-032 SHALL implement digit buffering, counting and comparison in sub-module code_entry, with outputs done and match as one-cycle pulses.

Verification
REQ-033 SHALL verify: rst, btn_arm, then keys 1,2,3,4 -> state 1->2, success=1, start=0 in the cycle after the 4th key.
REQ-034 SHALL verify: keys 1,2,3,5 -> tries_left 3->2, lockout=1 for 8 cycles; a key during lockout is ignored; then keys 1,2,3,4 -> DEFUSED.
REQ-035 SHALL verify: three wrong codes -> boom=1, state=3, tries_left=0.
REQ-036 SHALL verify: cnt = 8'hFF while ARMED -> EXPLODED next edge; the same with 4th correct digit in the same cycle -> EXPLODED.
REQ-037 SHALL verify: key_val=4'hA mid-entry -> not counted; 1,A,2,3,4 -> DEFUSED.
REQ-038 SHALL verify: rst pulse in ARMED -> all outputs 0 immediately (asynchronously), state=0; btn_arm after DEFUSED -> IDLE.
